// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture
// Receive-side monitor for a multiplexed seven-segment bus. Each scan strobe
// samples one digit's cathode pattern, decodes it back to a hex nibble and
// records it in a shadow frame. A frame is published once every digit has
// been seen at least once since the previous frame.
module seg7_scan_capture #(
  parameter int N_DIG       = 8,
  parameter bit CAT_ACT_LOW = 1'b1,
  parameter bit AN_ACT_LOW  = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 SAMPLE_CE,
  input  logic [6:0]           CAT,
  input  logic [N_DIG-1:0]     AN,
  output logic [4*N_DIG-1:0]   DIGITS,
  output logic [N_DIG-1:0]     DIG_BLANK,
  output logic                 FRAME_DONE,
  output logic [7:0]           FRAME_CNT,
  output logic                 CODE_ERR,
  output logic                 AN_ERR
);

  localparam logic [N_DIG-1:0] SEL_ONE = {{(N_DIG-1){1'b0}}, 1'b1};

  // Normalised, active-high views of the bus
  logic [6:0]       seg;
  logic [N_DIG-1:0] sel;

  // Decoder results for the current pattern
  logic [3:0] dec_nib;
  logic       dec_valid;
  logic       dec_blank;

  // Digit-select classification
  logic sel_onehot;
  logic sel_multi;

  // Per-digit capture strobe for this cycle (one-hot or zero)
  logic [N_DIG-1:0] hit;

  // Frame state
  logic [4*N_DIG-1:0] shadow_reg, shadow_next;
  logic [N_DIG-1:0]   blank_reg, blank_next;
  logic [N_DIG-1:0]   seen_reg, seen_next;
  logic               frame_complete;

  // Published outputs
  logic [4*N_DIG-1:0] digits_reg;
  logic [N_DIG-1:0]   dig_blank_reg;
  logic               frame_done_reg;
  logic [7:0]         frame_cnt_reg;
  logic               code_err_reg;
  logic               an_err_reg;

  assign seg = CAT_ACT_LOW ? ~CAT : CAT;
  assign sel = AN_ACT_LOW  ? ~AN  : AN;

  // Map the active-high segment pattern back to a nibble or blank
  always_comb begin
    dec_nib   = 4'h0;
    dec_valid = 1'b1;
    dec_blank = 1'b0;
    case (seg)
      7'h3F: dec_nib = 4'h0;
      7'h06: dec_nib = 4'h1;
      7'h5B: dec_nib = 4'h2;
      7'h4F: dec_nib = 4'h3;
      7'h66: dec_nib = 4'h4;
      7'h6D: dec_nib = 4'h5;
      7'h7D: dec_nib = 4'h6;
      7'h07: dec_nib = 4'h7;
      7'h7F: dec_nib = 4'h8;
      7'h6F: dec_nib = 4'h9;
      7'h77: dec_nib = 4'hA;
      7'h7C: dec_nib = 4'hB;
      7'h39: dec_nib = 4'hC;
      7'h5E: dec_nib = 4'hD;
      7'h79: dec_nib = 4'hE;
      7'h71: dec_nib = 4'hF;
      7'h00: begin
        dec_valid = 1'b0;
        dec_blank = 1'b1;
      end
      default: dec_valid = 1'b0;
    endcase
  end

  // A power-of-two test: exactly one bit set means a legal digit select
  assign sel_onehot = (sel != '0) && ((sel & (sel - SEL_ONE)) == '0);
  assign sel_multi  = (sel != '0) && !sel_onehot;

  // Only a legal select carrying a recognised pattern (or blank) is captured
  assign hit = (SAMPLE_CE && sel_onehot && (dec_valid || dec_blank)) ? sel : '0;

  // Per-digit next-state for the shadow frame
  generate
    for (genvar gi = 0; gi < N_DIG; gi++) begin : g_digit
      assign shadow_next[4*gi +: 4] = hit[gi] ? (dec_blank ? 4'h0 : dec_nib)
                                              : shadow_reg[4*gi +: 4];
      assign blank_next[gi]         = hit[gi] ? dec_blank : blank_reg[gi];
    end
  endgenerate

  // Completion includes the current sample's own contribution
  assign seen_next      = seen_reg | hit;
  assign frame_complete = &seen_next;

  // Shadow frame, seen mask and published frame
  always_ff @(posedge CLK) begin
    if (RST) begin
      shadow_reg     <= '0;
      blank_reg      <= '0;
      seen_reg       <= '0;
      digits_reg     <= '0;
      dig_blank_reg  <= '0;
      frame_done_reg <= 1'b0;
      frame_cnt_reg  <= 8'd0;
    end else begin
      shadow_reg     <= shadow_next;
      blank_reg      <= blank_next;
      frame_done_reg <= frame_complete;
      if (frame_complete) begin
        digits_reg    <= shadow_next;
        dig_blank_reg <= blank_next;
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
        seen_reg      <= '0;
      end else begin
        seen_reg      <= seen_next;
      end
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      code_err_reg <= 1'b0;
      an_err_reg   <= 1'b0;
    end else begin
      if (SAMPLE_CE && sel_multi)
        an_err_reg <= 1'b1;
      if (SAMPLE_CE && sel_onehot && !dec_valid && !dec_blank)
        code_err_reg <= 1'b1;
    end
  end

  assign DIGITS     = digits_reg;
  assign DIG_BLANK  = dig_blank_reg;
  assign FRAME_DONE = frame_done_reg;
  assign FRAME_CNT  = frame_cnt_reg;
  assign CODE_ERR   = code_err_reg;
  assign AN_ERR     = an_err_reg;

endmodule

// File: doc/seg7_scan_capture.md
Name: seg7_scan_capture

Overview:
- Receive-side monitor for the multiplexed 8-digit seven-segment bus (CAT/AN) driven by the nibble-entry display block.
- Samples the scanned cathode/anode lines on a scan strobe and decodes each segment pattern back to a hex nibble.
- Assembles a complete 8-digit frame and publishes it as a 32-bit word with per-digit blank flags, a frame pulse and error flags.
- Used in self-checking benches and for on-chip readback of what the display is actually showing.

Parameters:
- N_DIG, 8, number of scanned digits; AN width; DIGITS width = 4*N_DIG.
- CAT_ACT_LOW, 1, 1 = segment lit when CAT bit is 0.
- AN_ACT_LOW, 1, 1 = digit selected when AN bit is 0.

Ports:
- CLK  in  1  system clock; all state on rising edge.
- RST  in  1  synchronous, active-high reset.
- SAMPLE_CE  in  1  one-cycle scan strobe; CAT/AN are sampled only when high.
- CAT  in  7  segment lines {g,f,e,d,c,b,a}; CAT[0]=a.
- AN  in  N_DIG  digit select; AN[0] = rightmost digit = DIGITS[3:0].
- DIGITS  out  4*N_DIG  last complete frame; nibble i = DIGITS[4i+3:4i].
- DIG_BLANK  out  N_DIG  bit i = 1 if digit i was blank in the last frame.
- FRAME_DONE  out  1  one-cycle pulse when DIGITS/DIG_BLANK update.
- FRAME_CNT  out  8  completed-frame counter, wraps 255->0.
- CODE_ERR  out  1  sticky; unrecognised segment pattern seen.
- AN_ERR  out  1  sticky; more than one digit selected on a sample.

Behaviour:
- Reset: DIGITS=0, DIG_BLANK=0, FRAME_DONE=0, FRAME_CNT=0, CODE_ERR=0, AN_ERR=0, internal shadow=0, seen mask=0. RST overrides SAMPLE_CE in the same cycle.
- Normalisation: seg = CAT_ACT_LOW ? ~CAT : CAT; sel = AN_ACT_LOW ? ~AN : AN.
- Decode table (active-high seg hex -> nibble):
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->b, 39->C, 5E->d, 79->E, 71->F
  - 00 -> blank.
  - Any other pattern is a code error.
- Per-sample action, only when SAMPLE_CE=1:
  - sel == 0: idle (all digits off). No state change.
  - sel not one-hot: set AN_ERR. Sample is discarded.
  - sel one-hot at index i with a valid code: shadow[i] <= nibble, blank[i] <= 0, seen[i] <= 1.
  - sel one-hot at index i with blank (00): shadow[i] <= 0, blank[i] <= 1, seen[i] <= 1.
  - sel one-hot at index i with an invalid code: set CODE_ERR. seen[i] is not set.
  - Re-sampling an already-seen digit within the same frame overwrites it; the latest value wins.
- Frame completion: when the sample taken at cycle t makes seen all-ones (including that sample's own contribution), then on the edge ending cycle t:
  - DIGITS <= shadow with nibble i updated; DIG_BLANK <= blank likewise.
  - FRAME_DONE = 1 for exactly that one cycle.
  - FRAME_CNT increments.
  - seen clears to 0; the shadow is retained.
  - Latency from the completing strobe to FRAME_DONE/DIGITS valid: 1 clock.
- Scan order is irrelevant; completion only requires every digit to have been seen at least once.
- DIGITS/DIG_BLANK hold their values between frames. A partial frame never reaches the outputs.
- CODE_ERR and AN_ERR are sticky until RST. Neither error blocks frame assembly.
- SAMPLE_CE held high on consecutive cycles: each cycle is an independent sample.
- Reset mid-frame discards the partial frame and sets seen=0.

Test Plan:
1. After RST, scan AN=FE,FD,...,7F (one strobe each) with CAT encoding digits 7..0 = 0,0,0,0,0,0,2,3 (active-low CAT: 3=7'h30, 2=7'h24, 0=7'h40) -> FRAME_DONE pulses once, 1 clk after the 8th strobe; DIGITS=32'h00000023; DIG_BLANK=00; FRAME_CNT=1.
2. Scan digits 3..0 = 3,B,A,D (b=7'h03, A=7'h08, d=7'h21) with digits 7..4 blank (CAT=7'h7F), in reverse order AN=7F..FE -> DIGITS=32'h00003BAD; DIG_BLANK=F0.
3. Strobe digits 0-6 only, then hold 20 cycles with no strobe -> no FRAME_DONE and DIGITS unchanged. Strobe digit 0 twice (values 1 then 9), then digit 7 -> frame completes with nibble 0 = 9.
4. AN=8'hFC on one strobe -> AN_ERR=1, seen unchanged. CAT=7'h7E on AN=FE -> CODE_ERR=1. Both errors stay set through the next completed frame.
5. RST after 5 digits of a scan, then a full scan of F (7'h0E) on all digits -> DIGITS=32'hFFFFFFFF; FRAME_CNT=1; no stale nibbles.
6. Run 256 complete frames -> FRAME_CNT wraps to 0 with FRAME_DONE still pulsing; AN=8'hFF strobes interleaved between digits cause no effect.
